// File: rtl/jtag_shift_master.sv
// jtag_shift_master: fabric-side JTAG initiator for an external TAP.
// Runs one IR-scan, DR-scan or TAP-reset command at a time. The TCK it
// generates runs at f_clk/(2*DIV). TMS/TDI are updated on the clk edge that
// drives TCK low, and TDO is sampled on the clk edge that drives TCK high.
// Ports:
//   clk, rst_i                      clock, async active-high reset
//   cmd_valid/cmd_ready             command handshake (op, len, data)
//   cmd_op                          0=DR, 1=IR, 2=TAP reset, 3=error
//   cmd_len                         scan length 1..MAX_LEN
//   cmd_data                        TDI bits, LSB shifted first
//   rsp_valid/rsp_err/rsp_data      1-cycle completion pulse, error flag and captured TDO
//   busy                            inverse of cmd_ready
//   tck_o/tms_o/tdi_o/tdo_i         JTAG pins
// MAX_LEN must be at least 2.
module jtag_shift_master #(
    parameter int unsigned DIV     = 2,
    parameter int unsigned MAX_LEN = 32,
    localparam int unsigned LW     = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst_i,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [LW-1:0]      cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
    output logic               rsp_valid,
    output logic               rsp_err,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic               busy,
    output logic               tck_o,
    output logic               tms_o,
    output logic               tdi_o,
    input  logic               tdo_i
);

    localparam int unsigned DW = (DIV > 1) ? $clog2(DIV) : 1;
    // The step counter must also reach 5 for the reset sequences.
    localparam int unsigned SW = (LW > 3) ? LW : 3;

    localparam logic [1:0] OP_DR  = 2'd0;
    localparam logic [1:0] OP_IR  = 2'd1;
    localparam logic [1:0] OP_RST = 2'd2;

    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_LEAD, S_SHIFT, S_TAIL, S_RST, S_DONE
    } state_t;

    state_t             state, state_n;
    logic [SW-1:0]      step, step_n;
    logic [DW-1:0]      div_cnt;
    logic [1:0]         op_q;
    logic [LW-1:0]      len_q;
    logic               err_q;
    logic [MAX_LEN-1:0] data_sh;
    logic [MAX_LEN-1:0] cap;
    logic [MAX_LEN-1:0] mask;
    logic               tms_n, tdi_n;

    logic               running_c, tc_c, rise_c, fall_c, bad_c, err_eff_c;
    logic [1:0]         op_eff_c;
    logic [SW-1:0]      last_bit_c;

    assign running_c  = (state == S_INIT) || (state == S_LEAD) || (state == S_SHIFT) ||
                        (state == S_TAIL) || (state == S_RST);
    assign tc_c       = (div_cnt == DW'(DIV - 1));
    assign rise_c     = running_c && tc_c && !tck_o;
    assign fall_c     = running_c && tc_c && tck_o;
    assign bad_c      = (cmd_op == 2'd3) || (cmd_len == '0) || (cmd_len > LW'(MAX_LEN));
    // In IDLE the command fields are not latched yet, so use the live inputs.
    assign op_eff_c   = (state == S_IDLE) ? cmd_op : op_q;
    assign err_eff_c  = (state == S_IDLE) ? bad_c : err_q;
    assign last_bit_c = SW'(len_q) - SW'(1);

    // State register
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state <= S_INIT;
            step  <= '0;
        end else begin
            state <= state_n;
            step  <= step_n;
        end
    end

    // Next state; each step is one TCK period and ends on the falling TCK edge
    always_comb begin
        state_n = state;
        step_n  = step;
        tms_n   = tms_o;
        tdi_n   = tdi_o;
        unique case (state)
            S_INIT, S_RST: if (fall_c) begin
                if (step == SW'(5)) begin
                    state_n = (state == S_INIT) ? S_IDLE : S_DONE;
                    step_n  = '0;
                end else begin
                    step_n = step + SW'(1);
                end
            end
            S_IDLE: if (cmd_valid) begin
                step_n = '0;
                if (bad_c)                 state_n = S_DONE;
                else if (cmd_op == OP_RST) state_n = S_RST;
                else                       state_n = S_LEAD;
            end
            S_LEAD: if (fall_c) begin
                if (step == ((op_q == OP_IR) ? SW'(3) : SW'(2))) begin
                    state_n = S_SHIFT;
                    step_n  = '0;
                end else begin
                    step_n = step + SW'(1);
                end
            end
            S_SHIFT: if (fall_c) begin
                if (step == last_bit_c) begin
                    state_n = S_TAIL;
                    step_n  = '0;
                end else begin
                    step_n = step + SW'(1);
                end
            end
            S_TAIL: if (fall_c) begin
                if (step == SW'(1)) begin
                    state_n = S_DONE;
                    step_n  = '0;
                end else begin
                    step_n = step + SW'(1);
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_INIT;
        endcase

        // TMS/TDI for the upcoming TCK period, set only while TCK is low
        if (fall_c || (state == S_IDLE)) begin
            tdi_n = 1'b0;
            unique case (state_n)
                S_INIT, S_RST: tms_n = (step_n < SW'(5));
                S_LEAD:        tms_n = (op_eff_c == OP_IR) ? (step_n < SW'(2)) : (step_n == '0);
                S_SHIFT: begin
                    tms_n = (step_n == last_bit_c);
                    // data_sh shifts on this same edge when already shifting
                    tdi_n = (state == S_SHIFT) ? data_sh[1] : data_sh[0];
                end
                S_TAIL:        tms_n = (step_n == '0);
                default:       tms_n = 1'b0;
            endcase
        end
    end

    // TCK generation, shift datapath and registered outputs
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            tck_o     <= 1'b0;
            tms_o     <= 1'b1;
            tdi_o     <= 1'b0;
            div_cnt   <= '0;
            op_q      <= OP_DR;
            len_q     <= '0;
            err_q     <= 1'b0;
            data_sh   <= '0;
            cap       <= '0;
            mask      <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_data  <= '0;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
        end else begin
            tms_o <= tms_n;
            tdi_o <= tdi_n;

            if (running_c) begin
                if (tc_c) begin
                    div_cnt <= '0;
                    tck_o   <= ~tck_o;
                end else begin
                    div_cnt <= div_cnt + DW'(1);
                end
            end else begin
                div_cnt <= '0;
                tck_o   <= 1'b0;
            end

            if ((state == S_IDLE) && cmd_valid) begin
                op_q    <= cmd_op;
                len_q   <= cmd_len;
                err_q   <= bad_c;
                data_sh <= cmd_data;
                cap     <= '0;
                mask    <= MAX_LEN'(1);
            end

            // One-hot mask walks up so bit k captures the k-th shifted TDO bit
            if (rise_c && (state == S_SHIFT)) begin
                if (tdo_i) cap <= cap | mask;
                mask <= mask << 1;
            end
            if (fall_c && (state == S_SHIFT)) data_sh <= data_sh >> 1;

            rsp_valid <= (state_n == S_DONE);
            if (state_n == S_DONE) begin
                rsp_err  <= err_eff_c;
                rsp_data <= err_eff_c ? '0 : cap;
            end
            cmd_ready <= (state_n == S_IDLE);
            busy      <= (state_n != S_IDLE);
        end
    end

endmodule

// File: tb/tb_jtag_shift_master.sv
// tb_jtag_shift_master: directed bench for jtag_shift_master.
// The main instance runs with DIV=2. Two more instances, with DIV=1 and DIV=3,
// share the command inputs and loop TDO back to TDI. They are used for the
// TMS/TDI stability check.
module tb_jtag_shift_master;

    localparam int unsigned MAX_LEN = 32;
    localparam int unsigned LW      = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic               cmd_valid = 1'b0;
    logic [1:0]         cmd_op    = 2'd0;
    logic [LW-1:0]      cmd_len   = '0;
    logic [MAX_LEN-1:0] cmd_data  = '0;

    logic               m_ready, m_rsp_valid, m_rsp_err, m_busy, m_tck, m_tms, m_tdi, m_tdo;
    logic [MAX_LEN-1:0] m_rsp_data;
    logic               a_ready, a_rsp_valid, a_rsp_err, a_busy, a_tck, a_tms, a_tdi;
    logic [MAX_LEN-1:0] a_rsp_data;
    logic               b_ready, b_rsp_valid, b_rsp_err, b_busy, b_tck, b_tms, b_tdi;
    logic [MAX_LEN-1:0] b_rsp_data;

    logic loopback  = 1'b1;
    logic tdo_const = 1'b0;
    assign m_tdo = loopback ? m_tdi : tdo_const;

    jtag_shift_master #(.DIV(2), .MAX_LEN(MAX_LEN)) u_dut (
        .clk(clk), .rst_i(rst), .cmd_valid(cmd_valid), .cmd_ready(m_ready),
        .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data),
        .rsp_valid(m_rsp_valid), .rsp_err(m_rsp_err), .rsp_data(m_rsp_data),
        .busy(m_busy), .tck_o(m_tck), .tms_o(m_tms), .tdi_o(m_tdi), .tdo_i(m_tdo));

    jtag_shift_master #(.DIV(1), .MAX_LEN(MAX_LEN)) u_div1 (
        .clk(clk), .rst_i(rst), .cmd_valid(cmd_valid), .cmd_ready(a_ready),
        .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data),
        .rsp_valid(a_rsp_valid), .rsp_err(a_rsp_err), .rsp_data(a_rsp_data),
        .busy(a_busy), .tck_o(a_tck), .tms_o(a_tms), .tdi_o(a_tdi), .tdo_i(a_tdi));

    jtag_shift_master #(.DIV(3), .MAX_LEN(MAX_LEN)) u_div3 (
        .clk(clk), .rst_i(rst), .cmd_valid(cmd_valid), .cmd_ready(b_ready),
        .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data),
        .rsp_valid(b_rsp_valid), .rsp_err(b_rsp_err), .rsp_data(b_rsp_data),
        .busy(b_busy), .tck_o(b_tck), .tms_o(b_tms), .tdi_o(b_tdi), .tdo_i(b_tdi));

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Pin monitor: logs TMS/TDI at each rising TCK of the main instance, counts
    // responses and flags TMS/TDI changes while TCK is high or rising.
    int          n_tck = 0;
    int          n_rsp = 0;
    logic [63:0] tms_log = '0;
    logic [63:0] tdi_log = '0;
    int          viol_m = 0, viol_a = 0, viol_b = 0;
    logic        pm_tck = 1'b0, pm_tms = 1'b1, pm_tdi = 1'b0;
    logic        pa_tms = 1'b1, pa_tdi = 1'b0, pb_tms = 1'b1, pb_tdi = 1'b0;

    always @(negedge clk) begin
        if (m_tck && !pm_tck) begin
            if (n_tck < 64) begin
                tms_log[6'(n_tck)] = m_tms;
                tdi_log[6'(n_tck)] = m_tdi;
            end
            n_tck++;
        end
        if (m_rsp_valid) n_rsp++;
        if (m_tck && ((m_tms != pm_tms) || (m_tdi != pm_tdi))) viol_m++;
        if (a_tck && ((a_tms != pa_tms) || (a_tdi != pa_tdi))) viol_a++;
        if (b_tck && ((b_tms != pb_tms) || (b_tdi != pb_tdi))) viol_b++;
        pm_tck = m_tck; pm_tms = m_tms; pm_tdi = m_tdi;
        pa_tms = a_tms; pa_tdi = a_tdi;
        pb_tms = b_tms; pb_tdi = b_tdi;
    end

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            #1;
            if (m_ready && a_ready && b_ready) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic issue_cmd(input logic [1:0] op, input logic [LW-1:0] len,
                             input logic [MAX_LEN-1:0] data);
        bit ok;
        wait_ready(ok);
        chk("ready_wait", 64'(ok), 64'd1);
        cmd_op    = op;
        cmd_len   = len;
        cmd_data  = data;
        cmd_valid = 1'b1;
        @(posedge clk);
        n_tck   = 0;
        tms_log = '0;
        tdi_log = '0;
        #1;
        cmd_valid = 1'b0;
        cmd_data  = ~data;
    endtask

    task automatic wait_rsp(output logic [MAX_LEN-1:0] d, output logic e);
        bit got = 1'b0;
        d = '0;
        e = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (m_rsp_valid) begin
                got = 1'b1;
                d   = m_rsp_data;
                e   = m_rsp_err;
                break;
            end
        end
        chk("rsp_seen", 64'(got), 64'd1);
        @(negedge clk);
        chk("rsp_pulse", 64'(m_rsp_valid), 64'd0);
    endtask

    logic [MAX_LEN-1:0] d;
    logic               e;
    int                 rsp_before;
    bit                 ok;

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        n_tck = 0; tms_log = '0;
        @(negedge clk);
        chk("rst_tck",   64'(m_tck), 64'd0);
        chk("rst_tms",   64'(m_tms), 64'd1);
        chk("rst_tdi",   64'(m_tdi), 64'd0);
        chk("rst_ready", 64'(m_ready), 64'd0);
        chk("rst_busy",  64'(m_busy), 64'd1);
        chk("rst_rspv",  64'(m_rsp_valid), 64'd0);
        chk("rst_rspd",  64'(m_rsp_data), 64'd0);
        rst = 1'b0;

        // INIT: 6 TCKs with TMS 1,1,1,1,1,0
        wait_ready(ok);
        chk("init_ready", 64'(ok), 64'd1);
        chk("init_tcks",  64'(n_tck), 64'd6);
        chk("init_tms",   64'(tms_log[5:0]), 64'h1F);
        chk("idle_tck",   64'(m_tck), 64'd0);
        chk("idle_busy",  64'(m_busy), 64'd0);

        // DR len 8 loopback; cmd_valid pulses while busy must be ignored
        issue_cmd(2'd0, 6'd8, 32'hA5);
        cmd_valid = 1'b1; cmd_op = 2'd3; cmd_len = 6'd0;
        repeat (3) @(negedge clk);
        cmd_valid = 1'b0;
        wait_rsp(d, e);
        chk("dr8_data", 64'(d), 64'hA5);
        chk("dr8_err",  64'(e), 64'd0);
        chk("dr8_tcks", 64'(n_tck), 64'd13);
        chk("dr8_tms",  64'(tms_log[12:0]), 64'h0C01);
        chk("dr8_tdi",  64'(tdi_log[12:0]), 64'h0528);

        // IR len 4, TDO held high
        loopback = 1'b0; tdo_const = 1'b1;
        issue_cmd(2'd1, 6'd4, 32'h3);
        wait_rsp(d, e);
        chk("ir4_data", 64'(d), 64'hF);
        chk("ir4_tcks", 64'(n_tck), 64'd10);
        chk("ir4_tms",  64'(tms_log[9:0]), 64'h183);
        chk("ir4_tdi",  64'(tdi_log[9:0]), 64'h030);

        // DR len 1, TDO held low: Exit1 on the only shift bit
        tdo_const = 1'b0;
        issue_cmd(2'd0, 6'd1, 32'h1);
        wait_rsp(d, e);
        chk("dr1_data", 64'(d), 64'h0);
        chk("dr1_tcks", 64'(n_tck), 64'd6);
        chk("dr1_tms",  64'(tms_log[5:0]), 64'h19);

        // Full-width loopback
        loopback = 1'b1;
        issue_cmd(2'd0, 6'd32, 32'hDEADBEEF);
        wait_rsp(d, e);
        chk("dr32_data", 64'(d), 64'hDEADBEEF);
        chk("dr32_tcks", 64'(n_tck), 64'd37);

        // Bits at and above len read back as zero
        issue_cmd(2'd0, 6'd4, 32'hFF);
        wait_rsp(d, e);
        chk("dr4_data", 64'(d), 64'hF);

        // Error commands: no TCK activity, rsp_data cleared
        issue_cmd(2'd0, 6'd0, 32'h5);
        wait_rsp(d, e);
        chk("len0_err",  64'(e), 64'd1);
        chk("len0_data", 64'(d), 64'd0);
        chk("len0_tcks", 64'(n_tck), 64'd0);
        issue_cmd(2'd3, 6'd8, 32'h5);
        wait_rsp(d, e);
        chk("op3_err",  64'(e), 64'd1);
        chk("op3_tcks", 64'(n_tck), 64'd0);
        issue_cmd(2'd0, 6'd33, 32'h5);
        wait_rsp(d, e);
        chk("len33_err",  64'(e), 64'd1);
        chk("len33_tcks", 64'(n_tck), 64'd0);

        // TAP reset op
        issue_cmd(2'd2, 6'd8, 32'hFFFF);
        wait_rsp(d, e);
        chk("rst_op_err",  64'(e), 64'd0);
        chk("rst_op_data", 64'(d), 64'd0);
        chk("rst_op_tcks", 64'(n_tck), 64'd6);
        chk("rst_op_tms",  64'(tms_log[5:0]), 64'h1F);

        // Reset mid-scan after 5 shift bits (3 lead + 5 shift rising edges)
        issue_cmd(2'd0, 6'd16, 32'h1234);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            #1;
            if (n_tck >= 8) begin
                ok = 1'b1;
                break;
            end
        end
        chk("mid_reach", 64'(ok), 64'd1);
        chk("mid_tck_hi", 64'(m_tck), 64'd1);
        rsp_before = n_rsp;
        rst = 1'b1;
        #1;
        chk("mid_tck",   64'(m_tck), 64'd0);
        chk("mid_tms",   64'(m_tms), 64'd1);
        chk("mid_ready", 64'(m_ready), 64'd0);
        @(posedge clk);
        n_tck = 0; tms_log = '0;
        @(negedge clk);
        rst = 1'b0;
        wait_ready(ok);
        chk("reinit_ready", 64'(ok), 64'd1);
        chk("reinit_tcks",  64'(n_tck), 64'd6);
        chk("reinit_tms",   64'(tms_log[5:0]), 64'h1F);
        chk("no_rsp",       64'(n_rsp), 64'(rsp_before));
        issue_cmd(2'd0, 6'd8, 32'h3C);
        wait_rsp(d, e);
        chk("post_data", 64'(d), 64'h3C);
        chk("post_err",  64'(e), 64'd0);
        wait_ready(ok);

        // TMS/TDI never move while TCK is high or rising
        chk("stable_div2", 64'(viol_m), 64'd0);
        chk("stable_div1", 64'(viol_a), 64'd0);
        chk("stable_div3", 64'(viol_b), 64'd0);
        chk("div3_data",   64'(b_rsp_data), 64'h3C);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
